// File: rtl/i2c_reg_access_if.sv
// Host request/data streams plus the byte-master control and status bundle.
// slave = register-access block view, master = host and byte-master side.
interface i2c_reg_access_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [3:0] req_len;
  logic       wd_valid;
  logic       wd_ready;
  logic [7:0] wd_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       done;
  logic [1:0] err;
  logic [6:0] m_addr;
  logic       m_rw;
  logic [7:0] m_data;
  logic       m_enable;
  logic       m_ready;
  logic       m_data_rdy;
  logic       m_write_done;
  logic [7:0] m_data_out;

  modport slave (
    input  req_valid, req_rw, req_dev, req_reg, req_len, wd_valid, wd_data,
           m_ready, m_data_rdy, m_write_done, m_data_out,
    output req_ready, wd_ready, rd_valid, rd_data, done, err,
           m_addr, m_rw, m_data, m_enable
  );

  modport master (
    output req_valid, req_rw, req_dev, req_reg, req_len, wd_valid, wd_data,
           m_ready, m_data_rdy, m_write_done, m_data_out,
    input  req_ready, wd_ready, rd_valid, rd_data, done, err,
           m_addr, m_rw, m_data, m_enable
  );
endinterface

// File: rtl/i2c_reg_access.sv
// Sequences I2C register writes/reads onto a byte master; all outputs registered, one cycle after each master edge.
// Accepts one request at a time (req_ready only in IDLE); write data pulled by wd_ready, read data has no backpressure.
module i2c_reg_access #(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             rst,
  i2c_reg_access_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, W_ADDR, W_BYTES, W_END, P_ADDR, P_END, R_ADDR, R_BYTES, R_END, FIN
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [3:0]    len_q, len_d, cnt_q, cnt_d;
  logic          ptr_done_q, ptr_done_d;
  logic [TW-1:0] to_q, to_d;
  logic          rdy_prev_q, drdy_prev_q, wdone_prev_q;
  logic          req_ready_q, req_ready_d, wd_ready_q, wd_ready_d;
  logic          rd_valid_q, rd_valid_d, done_q, done_d;
  logic [7:0]    rd_data_q, rd_data_d, m_data_q, m_data_d;
  logic [1:0]    err_q, err_d;
  logic [6:0]    m_addr_q, m_addr_d;
  logic          m_rw_q, m_rw_d, m_enable_q, m_enable_d;
  logic          rdy_rise, rdy_fall, drdy_rise, wdone_rise, act;

  // Master status lines are levels; only their transitions carry meaning.
  assign rdy_rise   =  bus.m_ready      & ~rdy_prev_q;
  assign rdy_fall   = ~bus.m_ready      &  rdy_prev_q;
  assign drdy_rise  =  bus.m_data_rdy   & ~drdy_prev_q;
  assign wdone_rise =  bus.m_write_done & ~wdone_prev_q;

  always_comb begin
    state_d    = state_q;    dev_d      = dev_q;      reg_d    = reg_q;
    len_d      = len_q;      cnt_d      = cnt_q;      ptr_done_d = ptr_done_q;
    to_d       = to_q;       rd_data_d  = rd_data_q;  err_d    = err_q;
    m_addr_d   = m_addr_q;   m_rw_d     = m_rw_q;     m_data_d = m_data_q;
    m_enable_d = m_enable_q; wd_ready_d = 1'b0;       rd_valid_d = 1'b0;
    act        = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid && req_ready_q) begin
        dev_d      = bus.req_dev;
        reg_d      = bus.req_reg;
        len_d      = (bus.req_len == 4'd0) ? 4'd1 : bus.req_len;
        cnt_d      = 4'd0;
        ptr_done_d = 1'b0;
        err_d      = 2'd0;
        state_d    = bus.req_rw ? P_ADDR : W_ADDR;
      end
      W_ADDR, P_ADDR: begin
        if (!m_enable_q) begin
          if (bus.m_ready) begin
            m_enable_d = 1'b1;
            m_rw_d     = 1'b0;
            m_addr_d   = dev_q;
            m_data_d   = reg_q;
            act        = 1'b1;
          end
        end else if (rdy_fall) begin
          state_d = (state_q == W_ADDR) ? W_BYTES : P_END;
        end
      end
      W_BYTES: begin
        if (rdy_rise) begin
          err_d = 2'd1; m_enable_d = 1'b0; state_d = FIN;
        end else if (wdone_rise) begin
          act = 1'b1;
          if (cnt_q < len_q) begin
            if (bus.wd_valid) begin
              wd_ready_d = 1'b1;
              m_data_d   = bus.wd_data;
              cnt_d      = cnt_q + 4'd1;
            end else begin
              err_d = 2'd3; m_enable_d = 1'b0; state_d = W_END;
            end
          end else begin
            m_enable_d = 1'b0; state_d = W_END;
          end
        end
      end
      P_END: begin
        if (!ptr_done_q) begin
          if (rdy_rise) begin
            err_d = 2'd1; m_enable_d = 1'b0; state_d = FIN;
          end else if (wdone_rise) begin
            ptr_done_d = 1'b1; m_enable_d = 1'b0; act = 1'b1;
          end
        end else if (rdy_rise) begin
          state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (!m_enable_q) begin
          m_enable_d = 1'b1; m_rw_d = 1'b1; m_addr_d = dev_q; act = 1'b1;
        end else if (rdy_fall) begin
          state_d = R_BYTES;
          // A single-byte read must NACK its only byte.
          if (len_q == 4'd1) m_enable_d = 1'b0;
        end
      end
      R_BYTES: begin
        if (rdy_rise) begin
          err_d = 2'd1; m_enable_d = 1'b0; state_d = FIN;
        end else if (drdy_rise && (cnt_q < len_q)) begin
          act        = 1'b1;
          rd_valid_d = 1'b1;
          rd_data_d  = bus.m_data_out;
          cnt_d      = cnt_q + 4'd1;
          if (cnt_d == len_q - 4'd1) m_enable_d = 1'b0;
          if (cnt_d == len_q)        state_d = R_END;
        end
      end
      W_END, R_END: if (rdy_rise) state_d = FIN;
      FIN:          state_d = IDLE;
      default:      state_d = IDLE;
    endcase

    // Abort watchdog: restarted by any progress, fires only while a transfer is open.
    if (state_q == IDLE || state_q == FIN || state_d != state_q || act) begin
      to_d = '0;
    end else if (to_q == TO_LAST) begin
      to_d = '0; err_d = 2'd2; m_enable_d = 1'b0; state_d = FIN;
    end else begin
      to_d = to_q + TW'(1);
    end

    req_ready_d = (state_d == IDLE);
    done_d      = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;      dev_q <= '0;        reg_q <= '0;
      len_q <= '0;          cnt_q <= '0;        ptr_done_q <= 1'b0;
      to_q <= '0;           rdy_prev_q <= 1'b0; drdy_prev_q <= 1'b0;
      wdone_prev_q <= 1'b0; req_ready_q <= 1'b1; wd_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;   rd_data_q <= '0;    done_q <= 1'b0;
      err_q <= '0;          m_addr_q <= '0;     m_rw_q <= 1'b0;
      m_data_q <= '0;       m_enable_q <= 1'b0;
    end else begin
      state_q <= state_d;           dev_q <= dev_d;               reg_q <= reg_d;
      len_q <= len_d;               cnt_q <= cnt_d;               ptr_done_q <= ptr_done_d;
      to_q <= to_d;                 rdy_prev_q <= bus.m_ready;    drdy_prev_q <= bus.m_data_rdy;
      wdone_prev_q <= bus.m_write_done; req_ready_q <= req_ready_d; wd_ready_q <= wd_ready_d;
      rd_valid_q <= rd_valid_d;     rd_data_q <= rd_data_d;       done_q <= done_d;
      err_q <= err_d;               m_addr_q <= m_addr_d;         m_rw_q <= m_rw_d;
      m_data_q <= m_data_d;         m_enable_q <= m_enable_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.wd_ready  = wd_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_rw      = m_rw_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_enable  = m_enable_q;
endmodule

// File: tb/tb_i2c_reg_access.sv
// Directed bench: host request driver, write-data source, behavioural I2C byte master and a
// queue scoreboard for master bytes, ACK decisions, read data and completion codes.
module tb_i2c_reg_access;
  localparam int TO = 64;

  logic clk, rst;
  i2c_reg_access_if bus();

  i2c_reg_access #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0, errors = 0, rd_seen = 0, done_cnt = 0, wd_pulses = 0;
  logic dead, nack;
  logic [7:0] exp_start[$], exp_mbyte[$], exp_rd[$], slave_q[$], wd_src[$];
  logic [1:0] exp_err[$];
  logic       exp_ack[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-data source: holds each byte until a wd_ready handshake takes it.
  initial begin
    bus.wd_valid = 1'b0;
    bus.wd_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.wd_ready) begin
        wd_pulses++;
        if (bus.wd_valid) begin
          @(posedge clk);
          #1;
          void'(wd_src.pop_front());
        end
      end
      bus.wd_valid = (wd_src.size() > 0);
      bus.wd_data  = (wd_src.size() > 0) ? wd_src[0] : 8'h00;
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_valid) begin
        rd_seen++;
        chk("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) chk("rd_data", 32'(bus.rd_data), 32'(exp_rd.pop_front()));
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_expected", 32'(exp_err.size() > 0), 32'd1);
        if (exp_err.size() > 0) chk("err", 32'(bus.err), 32'(exp_err.pop_front()));
      end
    end
  end

  // Behavioural byte master.
  localparam int M_IDLE = 0, M_ADDR = 1, M_WBYTE = 2, M_WDONE = 3, M_RBYTE = 4,
                 M_RDY = 5, M_STOP = 6, M_WAITLOW = 7;
  int   ms, t;
  logic ack, rw_l;

  always @(negedge clk) begin
    if (rst) begin
      ms = M_IDLE; t = 0; ack = 1'b0; rw_l = 1'b0;
      bus.m_ready = 1'b1; bus.m_data_rdy = 1'b0; bus.m_write_done = 1'b0; bus.m_data_out = 8'h00;
    end else begin
      case (ms)
        M_IDLE: begin
          bus.m_ready = !dead;
          if (bus.m_enable && !dead) begin
            chk("start_rw_addr", 32'({bus.m_rw, bus.m_addr}),
                32'(exp_start.size() > 0 ? {1'b0, exp_start.pop_front()} : 9'h100));
            rw_l = bus.m_rw; bus.m_ready = 1'b0; t = 0; ms = M_ADDR;
          end
        end
        M_ADDR: begin
          t++;
          if (t == 4) begin
            t = 0;
            if (nack) ms = M_STOP;
            else if (!rw_l) begin
              chk("m_byte", 32'(bus.m_data),
                  32'(exp_mbyte.size() > 0 ? {1'b0, exp_mbyte.pop_front()} : 9'h100));
              ms = M_WBYTE;
            end else ms = M_RBYTE;
          end
        end
        M_WBYTE: begin
          t++;
          if (t == 4) begin bus.m_write_done = 1'b1; t = 0; ms = M_WDONE; end
        end
        M_WDONE: begin
          t++;
          if (t == 3) bus.m_write_done = 1'b0;
          if (t == 5) begin
            t = 0;
            if (bus.m_enable) begin
              chk("m_byte", 32'(bus.m_data),
                  32'(exp_mbyte.size() > 0 ? {1'b0, exp_mbyte.pop_front()} : 9'h100));
              ms = M_WBYTE;
            end else ms = M_STOP;
          end
        end
        M_RBYTE: begin
          t++;
          if (t == 2) begin
            ack = bus.m_enable;
            chk("ack", 32'(ack), 32'(exp_ack.size() > 0 ? {1'b0, exp_ack.pop_front()} : 2'h2));
          end
          if (t == 4) begin
            bus.m_data_out = (slave_q.size() > 0) ? slave_q.pop_front() : 8'hEE;
            bus.m_data_rdy = 1'b1; t = 0; ms = M_RDY;
          end
        end
        M_RDY: begin
          t++;
          if (t == 3) bus.m_data_rdy = 1'b0;
          if (t == 4) begin t = 0; ms = ack ? M_RBYTE : M_STOP; end
        end
        M_STOP: begin
          t++;
          if (t == 3) begin bus.m_ready = 1'b1; t = 0; ms = M_WAITLOW; end
        end
        M_WAITLOW: if (!bus.m_enable) ms = M_IDLE;
        default: ms = M_IDLE;
      endcase
    end
  end

  task automatic do_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [3:0] len);
    int n = 0;
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_rw = rw; bus.req_dev = dev; bus.req_reg = rg; bus.req_len = len;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    while (!bus.done && lat < budget) begin @(negedge clk); lat++; end
    chk("done_seen", 32'(bus.done), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic drained(input string tag);
    chk(tag, 32'(exp_start.size() + exp_mbyte.size() + exp_rd.size() + slave_q.size()
                 + wd_src.size() + exp_err.size() + exp_ack.size()), 32'd0);
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_m_enable"}, 32'(bus.m_enable), 32'd0);
    chk({tag, "_m_bus"}, 32'({bus.m_rw, bus.m_addr, bus.m_data}), 32'd0);
    chk({tag, "_streams"}, 32'({bus.wd_ready, bus.rd_valid, bus.rd_data}), 32'd0);
    chk({tag, "_done_err"}, 32'({bus.done, bus.err}), 32'd0);
  endtask

  initial begin
    int lat, p0, r0, d0, n;
    rst = 1'b1; dead = 1'b0; nack = 1'b0;
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_dev = '0; bus.req_reg = '0; bus.req_len = '0;
    repeat (3) @(negedge clk);
    idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Two-byte write.
    exp_start.push_back(8'h50);
    exp_mbyte.push_back(8'h10); exp_mbyte.push_back(8'hAA); exp_mbyte.push_back(8'hBB);
    wd_src.push_back(8'hAA); wd_src.push_back(8'hBB);
    exp_err.push_back(2'd0);
    p0 = wd_pulses;
    do_req(1'b0, 7'h50, 8'h10, 4'd2);
    wait_done(2000, lat);
    drained("wr2_drained");
    chk("wr2_wd_pulses", 32'(wd_pulses - p0), 32'd2);

    // Three-byte read: last byte NACKed.
    exp_start.push_back(8'h68); exp_start.push_back({1'b1, 7'h68});
    exp_mbyte.push_back(8'h3B);
    slave_q.push_back(8'h01); slave_q.push_back(8'h02); slave_q.push_back(8'h03);
    exp_rd.push_back(8'h01); exp_rd.push_back(8'h02); exp_rd.push_back(8'h03);
    exp_ack.push_back(1'b1); exp_ack.push_back(1'b1); exp_ack.push_back(1'b0);
    exp_err.push_back(2'd0);
    r0 = rd_seen;
    do_req(1'b1, 7'h68, 8'h3B, 4'd3);
    wait_done(2000, lat);
    drained("rd3_drained");
    chk("rd3_count", 32'(rd_seen - r0), 32'd3);

    // Single-byte read.
    exp_start.push_back(8'h68); exp_start.push_back({1'b1, 7'h68});
    exp_mbyte.push_back(8'h75);
    slave_q.push_back(8'h9C); exp_rd.push_back(8'h9C);
    exp_ack.push_back(1'b0);
    exp_err.push_back(2'd0);
    r0 = rd_seen;
    do_req(1'b1, 7'h68, 8'h75, 4'd1);
    wait_done(2000, lat);
    drained("rd1_drained");
    chk("rd1_count", 32'(rd_seen - r0), 32'd1);

    // Write underflow on the second data byte.
    exp_start.push_back(8'h50);
    exp_mbyte.push_back(8'h20); exp_mbyte.push_back(8'h11);
    wd_src.push_back(8'h11);
    exp_err.push_back(2'd3);
    p0 = wd_pulses;
    do_req(1'b0, 7'h50, 8'h20, 4'd3);
    wait_done(2000, lat);
    drained("underflow_drained");
    chk("underflow_wd_pulses", 32'(wd_pulses - p0), 32'd1);

    // Address NACK on a read.
    nack = 1'b1;
    exp_start.push_back(8'h33);
    exp_err.push_back(2'd1);
    r0 = rd_seen;
    do_req(1'b1, 7'h33, 8'h01, 4'd2);
    wait_done(2000, lat);
    nack = 1'b0;
    drained("nack_drained");
    chk("nack_rd_count", 32'(rd_seen - r0), 32'd0);

    // Dead master: never ready.
    dead = 1'b1;
    repeat (2) @(negedge clk);
    exp_err.push_back(2'd2);
    do_req(1'b0, 7'h50, 8'h00, 4'd1);
    wait_done(TO * 4, lat);
    chk("timeout_latency_in_window", 32'(lat >= TO - 1 && lat <= TO + 1), 32'd1);
    chk("timeout_m_enable", 32'(bus.m_enable), 32'd0);
    dead = 1'b0;
    repeat (3) @(negedge clk);
    drained("timeout_drained");

    // Reset while bytes are being read.
    exp_start.push_back(8'h68); exp_start.push_back({1'b1, 7'h68});
    exp_mbyte.push_back(8'h3B);
    slave_q.push_back(8'h41); slave_q.push_back(8'h42); slave_q.push_back(8'h43);
    exp_rd.push_back(8'h41); exp_rd.push_back(8'h42); exp_rd.push_back(8'h43);
    exp_ack.push_back(1'b1); exp_ack.push_back(1'b1); exp_ack.push_back(1'b0);
    exp_err.push_back(2'd0);
    r0 = rd_seen;
    do_req(1'b1, 7'h68, 8'h3B, 4'd3);
    n = 0;
    while (rd_seen == r0 && n < 2000) begin @(negedge clk); n++; end
    chk("midread_first_byte", 32'(rd_seen - r0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    idle_outputs("midreset");
    exp_start.delete(); exp_mbyte.delete(); exp_rd.delete(); slave_q.delete();
    exp_ack.delete(); exp_err.delete(); wd_src.delete();
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    chk("midreset_no_done", 32'(done_cnt - d0), 32'd0);

    // Write after reset, req_len=0 taken as one byte.
    exp_start.push_back(8'h50);
    exp_mbyte.push_back(8'h11); exp_mbyte.push_back(8'h5A);
    wd_src.push_back(8'h5A);
    exp_err.push_back(2'd0);
    p0 = wd_pulses;
    do_req(1'b0, 7'h50, 8'h11, 4'd0);
    wait_done(2000, lat);
    drained("postreset_drained");
    chk("postreset_wd_pulses", 32'(wd_pulses - p0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
